// File: rtl/track_switch_pkg.sv
// track_switch_pkg: shared FSM state type, default parameters and width helpers
package track_switch_pkg;
    typedef enum logic [1:0] {IDLE, MOVE, LOCKED, CLEAR} state_t;
    localparam int DEF_N_TRACKS     = 4;
    localparam int DEF_DEBOUNCE_CYC = 4;
    localparam int DEF_SETTLE_CYC   = 8;
    localparam int DEF_HOLD_CYC     = 16;
    function automatic int cnt_w(int a, int b, int c);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return $clog2(m + 1);
    endfunction
    function automatic int idx_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/track_switch_ctrl_if.sv
// track_switch_ctrl_if: sensor inputs and route outputs of the junction controller
interface track_switch_ctrl_if
    import track_switch_pkg::*;
#(
    parameter int N_TRACKS = DEF_N_TRACKS
);
    localparam int IW = idx_w(N_TRACKS);
    logic [N_TRACKS-1:0] sensor;
    logic [N_TRACKS-1:0] switch_out;
    logic                route_valid;
    logic                busy;
    logic                conflict;
    logic [IW-1:0]       grant_idx;
    modport master(output sensor, input switch_out, route_valid, busy, conflict, grant_idx);
    modport slave(input sensor, output switch_out, route_valid, busy, conflict, grant_idx);
endinterface

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchroniser followed by a consecutive-cycle stability filter
module sensor_debounce
    import track_switch_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rest,
    input  logic raw,
    output logic req
);
    localparam int CW = cnt_w(DEBOUNCE_CYC, 1, 1);
    logic          s1, s2;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rest) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            req <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == req) cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                req <= s2;
                cnt <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/track_switch_ctrl.sv
// track_switch_ctrl: N-way junction controller granting one debounced route at a time
// Define TRACK_SWITCH_RR_EN for round-robin arbitration instead of fixed priority.
module track_switch_ctrl
    import track_switch_pkg::*;
#(
    parameter int N_TRACKS     = DEF_N_TRACKS,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC
) (
    input  logic               clk,
    input  logic               rest,
    track_switch_ctrl_if.slave bus
);
    localparam int IW = idx_w(N_TRACKS);
    localparam int CW = cnt_w(DEBOUNCE_CYC, SETTLE_CYC, HOLD_CYC);
    logic [N_TRACKS-1:0] req, oh_n;
    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [IW-1:0]       grant, grant_n, pick, idx, base;
    logic                found;
    for (genvar i = 0; i < N_TRACKS; i++) begin : g_deb
        sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
            .clk(clk), .rest(rest), .raw(bus.sensor[i]), .req(req[i])
        );
    end
`ifdef TRACK_SWITCH_RR_EN
    logic [IW-1:0] rr;
    always_ff @(posedge clk) begin
        if (rest) rr <= '0;
        else if (state == IDLE && |req) rr <= IW'((int'(pick) + 1) % N_TRACKS);
    end
    assign base = rr;
`else
    assign base = '0;
`endif
    // First active request found when scanning upward (wrapping) from base.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N_TRACKS; k++) begin
            idx = IW'((int'(base) + k) % N_TRACKS);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        grant_n = grant;
        case (state)
            IDLE: if (|req) begin
                state_n = MOVE;
                grant_n = pick;
                cnt_n   = CW'(SETTLE_CYC - 1);
            end
            MOVE: if (cnt == '0) state_n = LOCKED;
                  else cnt_n = cnt - 1'b1;
            LOCKED: if (!req[grant]) begin
                state_n = CLEAR;
                cnt_n   = CW'(HOLD_CYC - 1);
            end
            CLEAR: if (req[grant]) state_n = LOCKED;
                   else if (cnt == '0) state_n = IDLE;
                   else cnt_n = cnt - 1'b1;
            default: state_n = IDLE;
        endcase
        oh_n = N_TRACKS'(1) << grant_n;
    end
    always_ff @(posedge clk) begin
        if (rest) begin
            state           <= IDLE;
            cnt             <= '0;
            grant           <= '0;
            bus.switch_out  <= '0;
            bus.route_valid <= 1'b0;
            bus.busy        <= 1'b0;
            bus.conflict    <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            grant           <= grant_n;
            bus.switch_out  <= state_n != IDLE ? oh_n : '0;
            bus.route_valid <= state_n == LOCKED || state_n == CLEAR;
            bus.busy        <= state_n != IDLE;
            bus.conflict    <= state_n != IDLE && |(req & ~oh_n);
        end
    end
    assign bus.grant_idx = grant;
endmodule

// File: tb/tb_track_switch_ctrl.sv
// tb_track_switch_ctrl: directed scenarios plus random sensor traffic against a route-level model
module tb_track_switch_ctrl;
    localparam int N = 4, DB = 4, ST = 8, HD = 16;
    logic clk = 1'b0;
    logic rest = 1'b1;
    int checks = 0, errors = 0;
    int n;
    logic [N-1:0] s;
    track_switch_ctrl_if #(.N_TRACKS(N)) bus ();
    track_switch_ctrl #(.N_TRACKS(N), .DEBOUNCE_CYC(DB), .SETTLE_CYC(ST), .HOLD_CYC(HD)) dut (
        .clk(clk), .rest(rest), .bus(bus.slave)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Route-level model: sensors pass a 2-deep delay line, then must differ from the
    // filtered level for DB cycles; a route is on for ST settle cycles, stays while
    // occupied, then lingers HD cycles after the train leaves.
    logic [N-1:0] m_s1, m_s2, m_req;
    int  m_run[N];
    bit  m_on, m_holding, m_conf, m_found;
    int  m_g, m_settle, m_hold, m_ptr, m_j;
    always @(posedge clk) begin
        if (rest) begin
            m_s1 = '0; m_s2 = '0; m_req = '0;
            foreach (m_run[i]) m_run[i] = 0;
            m_on = 0; m_holding = 0; m_conf = 0;
            m_g = 0; m_settle = 0; m_hold = 0; m_ptr = 0;
        end else begin
            if (!m_on) begin
                m_found = 0;
                for (int k = 0; k < N; k++) begin
`ifdef TRACK_SWITCH_RR_EN
                    m_j = (m_ptr + k) % N;
`else
                    m_j = k;
`endif
                    if (!m_found && m_req[m_j]) begin
                        m_found = 1; m_on = 1; m_g = m_j; m_settle = ST; m_holding = 0;
                        m_ptr = (m_j + 1) % N;
                    end
                end
            end else if (m_settle > 0) m_settle--;
            else if (!m_holding) begin
                if (!m_req[m_g]) begin m_holding = 1; m_hold = HD; end
            end else if (m_req[m_g]) m_holding = 0;
            else begin
                m_hold--;
                if (m_hold == 0) begin m_on = 0; m_holding = 0; end
            end
            m_conf = 0;
            for (int k = 0; k < N; k++) if (m_on && k != m_g && m_req[k]) m_conf = 1;
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] != m_req[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin m_req[i] = m_s2[i]; m_run[i] = 0; end
                end else m_run[i] = 0;
            end
            m_s2 = m_s1;
            m_s1 = bus.sensor;
        end
    end
    always @(negedge clk) begin
        check("switch_out", 32'(bus.switch_out), m_on ? 32'(1) << m_g : 32'd0);
        check("route_valid", 32'(bus.route_valid), 32'(m_on && m_settle == 0));
        check("busy", 32'(bus.busy), 32'(m_on));
        check("conflict", 32'(bus.conflict), 32'(m_conf));
        check("grant_idx", 32'(bus.grant_idx), 32'(m_g));
    end
    task automatic do_reset();
        rest = 1'b1;
        @(negedge clk);
        rest = 1'b0;
    endtask
    task automatic wait_route(input int limit, output int cyc);
        cyc = 0;
        while (bus.switch_out == '0 && cyc < limit) begin @(negedge clk); cyc++; end
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
    initial begin
        bus.sensor = '0;
        repeat (3) @(negedge clk);
        rest = 1'b0;
        bus.sensor = 4'b0010;
        wait_route(20, n);
        check("t1_latency", 32'(n), 32'd7);
        repeat (40) @(negedge clk);
        bus.sensor = '0;
        repeat (40) @(negedge clk);
        bus.sensor = 4'b0001;
        repeat (2) @(negedge clk);
        bus.sensor = '0;
        repeat (20) @(negedge clk);
        check("t2_no_route", 32'(bus.switch_out), 32'd0);
        do_reset();
        bus.sensor = 4'b1010;
        repeat (10) @(negedge clk);
        check("t3_grant", 32'(bus.grant_idx), 32'd1);
        check("t3_conflict", 32'(bus.conflict), 32'd1);
        repeat (20) @(negedge clk);
        bus.sensor = 4'b1000;
        n = 0;
        while (bus.grant_idx != 2'd3 && n < 80) begin @(negedge clk); n++; end
        check("t3_pending_grant", 32'(bus.grant_idx), 32'd3);
        bus.sensor = '0;
        repeat (60) @(negedge clk);
        do_reset();
        bus.sensor = 4'b0010;
        repeat (30) @(negedge clk);
        bus.sensor = '0;
        repeat (11) @(negedge clk);
        bus.sensor = 4'b0010;
        repeat (20) begin
            @(negedge clk);
            check("t4_relock", 32'(bus.route_valid), 32'd1);
        end
        repeat (10) @(negedge clk);
        rest = 1'b1;
        @(negedge clk);
        check("t5_reset_sw", 32'(bus.switch_out), 32'd0);
        check("t5_reset_busy", 32'(bus.busy), 32'd0);
        rest = 1'b0;
        wait_route(20, n);
        check("t5_regrant", 32'(n), 32'd7);
        bus.sensor = '0;
        repeat (50) @(negedge clk);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            bus.sensor = '1;
            n = 0;
            while (!bus.route_valid && n < 40) begin @(negedge clk); n++; end
`ifdef TRACK_SWITCH_RR_EN
            check("t6_grant", 32'(bus.grant_idx), 32'(k % N));
`else
            check("t6_grant", 32'(bus.grant_idx), 32'd0);
`endif
            bus.sensor = '0;
            n = 0;
            while (bus.busy && n < 80) begin @(negedge clk); n++; end
            check("t6_idle", 32'(bus.busy), 32'd0);
        end
        for (int r = 0; r < 250; r++) begin
            if ($urandom_range(0, 40) == 0) do_reset();
            s = bus.sensor;
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) s[i] = ~s[i];
            bus.sensor = s;
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
